// File: rtl/match_window_counter.sv
// rtl/match_window_counter.sv - saturating match total plus per-window match counts with valid/ready hand-off
//
// Counts the one-bit MATCH flag from pattern_detector1 while enabled. It keeps a
// saturating running total and a per-window count. Each completed window is
// offered to a reader over WIN_VALID/WIN_READY. Overrun and alarm flags are sticky.
//
// Build option: define MATCH_ALARM_EN to compile in the THRESH comparator and
// the ALARM register. Without it, ALARM is tied to 0.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   EN         in   counting enable (IDLE <-> RUN)
//   MATCH      in   match flag, one count per sampled high RUN cycle
//   CLEAR      in   synchronous clear of TOTAL, ALARM, OVERRUN
//   WIN_READY  in   reader accepts the pending window result
//   TOTAL      out  saturating count of matches sampled in RUN
//   WIN_COUNT  out  match count of the most recently completed window
//   WIN_VALID  out  WIN_COUNT holds an unconsumed result
//   OVERRUN    out  sticky: a result was overwritten before acceptance
//   ALARM      out  sticky: some completed window reached THRESH
module match_window_counter #(
    parameter int CNT_WIDTH = 8,
    parameter int WIN_LEN   = 16,
    parameter int WIN_WIDTH = 5,
    parameter int THRESH    = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 EN,
    input  logic                 MATCH,
    input  logic                 CLEAR,
    input  logic                 WIN_READY,
    output logic [CNT_WIDTH-1:0] TOTAL,
    output logic [WIN_WIDTH-1:0] WIN_COUNT,
    output logic                 WIN_VALID,
    output logic                 OVERRUN,
    output logic                 ALARM
);

    localparam int IDX_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(WIN_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] TOTAL_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [WIN_WIDTH-1:0] acc;

    // Accumulator including the current cycle's MATCH; only meaningful in RUN.
    logic [WIN_WIDTH-1:0] acc_next;
    logic                 completing;
    logic                 transfer;

    always_comb begin
        acc_next   = acc + {{(WIN_WIDTH-1){1'b0}}, MATCH};
        completing = (state == RUN) && EN && (idx == LAST_IDX);
        transfer   = WIN_VALID && WIN_READY;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            TOTAL     <= '0;
            WIN_COUNT <= '0;
            WIN_VALID <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            // Running total: CLEAR beats a same-cycle match.
            if (CLEAR) begin
                TOTAL <= '0;
            end else if ((state == RUN) && EN && MATCH && (TOTAL != TOTAL_MAX)) begin
                TOTAL <= TOTAL + CNT_WIDTH'(1);
            end

            // Sticky overrun: the set below is written later so it wins over CLEAR.
            if (CLEAR) begin
                OVERRUN <= 1'b0;
            end

            // Handshake drop; a completion on the same edge re-asserts below.
            if (transfer) begin
                WIN_VALID <= 1'b0;
            end

            case (state)
                IDLE: begin
                    idx <= '0;
                    acc <= '0;
                    if (EN) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!EN) begin
                        // Partial window is discarded.
                        state <= IDLE;
                        idx   <= '0;
                        acc   <= '0;
                    end else if (completing) begin
                        idx       <= '0;
                        acc       <= '0;
                        WIN_COUNT <= acc_next;
                        WIN_VALID <= 1'b1;
                        if (WIN_VALID && !WIN_READY) begin
                            OVERRUN <= 1'b1;
                        end
                    end else begin
                        idx <= idx + IDX_W'(1);
                        acc <= acc_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    acc   <= '0;
                end
            endcase
        end
    end

`ifdef MATCH_ALARM_EN
    localparam logic [WIN_WIDTH-1:0] THRESH_V = WIN_WIDTH'(THRESH);

    always_ff @(posedge clock) begin
        if (reset) begin
            ALARM <= 1'b0;
        end else if (completing && (acc_next >= THRESH_V)) begin
            ALARM <= 1'b1;
        end else if (CLEAR) begin
            ALARM <= 1'b0;
        end
    end
`else
    assign ALARM = 1'b0;
`endif

endmodule

// File: tb/tb_match_window_counter.sv
// tb/tb_match_window_counter.sv - directed table-driven bench for match_window_counter
module tb_match_window_counter;

`ifdef MATCH_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       match = 1'b0;
    logic       clear = 1'b0;
    logic       win_ready = 1'b0;
    logic [7:0] total;
    logic [4:0] win_count;
    logic       win_valid;
    logic       overrun;
    logic       alarm;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    match_window_counter #(
        .CNT_WIDTH(8),
        .WIN_LEN  (16),
        .WIN_WIDTH(5),
        .THRESH   (3)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .EN       (en),
        .MATCH    (match),
        .CLEAR    (clear),
        .WIN_READY(win_ready),
        .TOTAL    (total),
        .WIN_COUNT(win_count),
        .WIN_VALID(win_valid),
        .OVERRUN  (overrun),
        .ALARM    (alarm)
    );

    typedef struct {
        int   n;
        logic rst;
        logic e;
        logic m;
        logic clr;
        logic rdy;
        logic chk;
        int   tot;
        int   wc;
        logic wv;
        logic ov;
        logic al;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic rst, input logic e, input logic m,
                       input logic clr, input logic rdy, input logic chk,
                       input int tot, input int wc, input logic wv, input logic ov,
                       input logic al);
        vec_t v;
        v.n = n; v.rst = rst; v.e = e; v.m = m; v.clr = clr; v.rdy = rdy;
        v.chk = chk; v.tot = tot; v.wc = wc; v.wv = wv; v.ov = ov; v.al = al;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s (vector %0d): got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic e, input logic m, input logic clr,
                        input logic rdy);
        reset = rst; en = e; match = m; clear = clr; win_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    initial begin
        //   n  rst en m clr rdy chk tot wc wv ov al
        add( 1, 1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0); // 0 reset
        add( 1, 0, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0); // 1 enter RUN
        add( 2, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0); // idx 0-1
        add( 1, 0, 1, 1, 0, 0, 1,   1, 0, 0, 0, 0); // 3 idx 2 match
        add( 2, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add( 1, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0); // idx 5
        add( 3, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add( 1, 0, 1, 1, 0, 0, 1,   3, 0, 0, 0, 0); // 7 idx 9
        add( 5, 0, 1, 0, 0, 0, 1,   3, 0, 0, 0, 0); // 8 idx 10-14
        add( 1, 0, 1, 0, 0, 0, 1,   3, 3, 1, 0, 1); // 9 completion
        add( 1, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0);
        add(15, 0, 1, 0, 0, 0, 1,   4, 1, 1, 1, 1); // 11 overwrite -> overrun
        add( 2, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0);
        add(14, 0, 1, 0, 0, 0, 1,   6, 2, 1, 1, 1); // 13
        add( 1, 0, 1, 0, 0, 1, 1,   6, 2, 0, 1, 1); // 14 accepted
        add( 1, 0, 0, 0, 0, 0, 1,   6, 2, 0, 1, 1); // 15 to IDLE
        add( 1, 0, 0, 0, 1, 0, 1,   0, 2, 0, 0, 0); // 16 CLEAR
        add( 1, 0, 1, 0, 0, 0, 1,   0, 2, 0, 0, 0); // 17 enter RUN
        add( 4, 0, 1, 1, 0, 0, 1,   4, 2, 0, 0, 0); // 18 idx 0-3
        add( 6, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0); // idx 4-9
        add( 1, 0, 0, 0, 0, 0, 1,   4, 2, 0, 0, 0); // 20 EN=0 at idx 10
        add( 3, 0, 0, 0, 0, 0, 1,   4, 2, 0, 0, 0); // 21
        add( 1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0); // re-enter
        add(15, 0, 1, 0, 0, 0, 1,   4, 2, 0, 0, 0); // 23 idx 0-14, no result yet
        add( 1, 0, 1, 0, 0, 0, 1,   4, 0, 1, 0, 0); // 24 full 16 cycles
        add( 1, 0, 1, 1, 1, 1, 1,   0, 0, 0, 0, 0); // 25 CLEAR beats MATCH
        add( 4, 0, 1, 1, 0, 0, 1,   4, 0, 0, 0, 0); // 26
        add(10, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add( 1, 0, 1, 0, 1, 0, 1,   0, 5, 1, 0, 1); // 28 CLEAR vs alarm set
        add( 1, 1, 1, 1, 0, 0, 1,   0, 0, 0, 0, 0); // 29 reset mid-handshake
        add( 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0); // 30
        add( 1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0); // enter
        add(16, 0, 1, 0, 0, 0, 1,   0, 0, 1, 0, 0); // 32 empty window
        add(15, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0);
        add( 1, 0, 1, 1, 0, 1, 1,  16, 16, 1, 0, 1); // 34 completion + transfer
        add( 1, 0, 1, 0, 0, 1, 1,  16, 16, 0, 0, 1); // 35

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                step(vecs[i].rst, vecs[i].e, vecs[i].m, vecs[i].clr, vecs[i].rdy);
            end
            if (vecs[i].chk) begin
                cmp("TOTAL", i, int'(total), vecs[i].tot);
                cmp("WIN_COUNT", i, int'(win_count), vecs[i].wc);
                cmp("WIN_VALID", i, int'(win_valid), int'(vecs[i].wv));
                cmp("OVERRUN", i, int'(overrun), int'(vecs[i].ov));
                cmp("ALARM", i, int'(alarm), ALARM_ON ? int'(vecs[i].al) : 0);
            end
        end

        // Saturation with a reader that is always ready.
        begin
            int n_valid;
            int saw_ov;
            n_valid = 0;
            saw_ov  = 0;
            step(1, 0, 0, 0, 1);
            step(0, 1, 0, 0, 1);
            for (int c = 1; c <= 300; c++) begin
                step(0, 1, 1, 0, 1);
                if (overrun) saw_ov = 1;
                if (win_valid) begin
                    n_valid++;
                    cmp("sat_win_count", c, int'(win_count), 16);
                end
                if (c == 254) cmp("sat_total_254", c, int'(total), 254);
                if (c == 255) cmp("sat_total_255", c, int'(total), 255);
            end
            cmp("sat_total_end", 300, int'(total), 255);
            cmp("sat_windows", 300, n_valid, 18);
            cmp("sat_overrun", 300, saw_ov, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/match_window_counter.md
# match_window_counter

Downstream consumer of `pattern_detector1`. It takes the detector's one-bit `OUT` match flag and keeps a saturating running total of matches. It also counts matches per fixed-length observation window and hands each completed window count to a reader over a valid/ready handshake. Overrun and threshold-alarm flags are sticky.

## Interface

Parameters:
- `CNT_WIDTH`, 8: width of the running total.
- `WIN_LEN`, 16: RUN cycles per window; must be at least 2.
- `WIN_WIDTH`, 5: width of the window count; must represent `WIN_LEN`.
- `THRESH`, 3: window count at or above which `ALARM` sets.

Ports:
- `clock`, in, 1: single clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `EN`, in, 1: counting enable.
- `MATCH`, in, 1: connects to `pattern_detector1` `OUT`. Each sampled high cycle counts as one match.
- `CLEAR`, in, 1: synchronous clear of `TOTAL`, `ALARM` and `OVERRUN`.
- `WIN_READY`, in, 1: reader accepts the current window result.
- `TOTAL`, out, `CNT_WIDTH`: saturating count of matches sampled in RUN.
- `WIN_COUNT`, out, `WIN_WIDTH`: match count of the most recently completed window.
- `WIN_VALID`, out, 1: `WIN_COUNT` holds an unconsumed result.
- `OVERRUN`, out, 1: sticky; a window result was overwritten before it was accepted.
- `ALARM`, out, 1: sticky; some completed window reached `THRESH`.

## Operation

- **Reset:**
  - FSM goes to IDLE.
  - Cycle index, window accumulator, `TOTAL`, `WIN_COUNT`, `WIN_VALID`, `OVERRUN` and `ALARM` all go to 0.
  - Reset overrides every other input, including mid-window and mid-handshake.
- **FSM states:**
  - IDLE: cycle index and accumulator are held at 0; `MATCH` is ignored. Goes to RUN at the first edge where `EN`=1.
  - RUN: samples `MATCH` every cycle. Goes to IDLE at any edge where `EN`=0; the partial window is discarded and no `WIN_VALID` is produced.
- **Window counting in RUN:**
  - Cycle index runs 0 to `WIN_LEN`-1, then wraps to 0.
  - At index `WIN_LEN`-1, completion happens. `WIN_COUNT` loads the accumulator plus that cycle's `MATCH`, `WIN_VALID` is set, and the accumulator restarts at 0.
  - The accumulator never exceeds `WIN_LEN`, so it needs no saturation.
- **`TOTAL`:**
  - Increments on each RUN cycle with `MATCH`=1 and saturates at all-ones.
  - If `CLEAR` and `MATCH` occur in the same cycle, `CLEAR` wins and the next `TOTAL` is 0.
- **Handshake:**
  - Transfer happens on an edge where `WIN_VALID`=1 and `WIN_READY`=1; `WIN_VALID` drops at that edge.
  - If a completion lands on the same edge as a transfer, the new result loads, `WIN_VALID` stays 1, and no overrun is recorded.
  - If a completion lands while `WIN_VALID`=1 and `WIN_READY`=0, `WIN_COUNT` is overwritten with the newest result and `OVERRUN` sets.
  - `WIN_READY` is ignored while `WIN_VALID`=0.
- **Sticky flags:**
  - `OVERRUN` and `ALARM` clear only on `CLEAR` or `reset`.
  - If `CLEAR` coincides with a setting event, the set wins and the flag ends at 1.
  - `TOTAL` is still cleared in that case.

## Timing

- `WIN_VALID` and the new `WIN_COUNT` appear one edge after the `WIN_LEN`-th RUN cycle is sampled.
- `TOTAL` is updated one edge after `MATCH` is sampled.
- `ALARM` sets on the same edge as the completion that qualifies it.
- `OVERRUN` sets on the same edge as the completion that overwrites an unaccepted result.
- The first RUN cycle (index 0) is the first cycle after the IDLE to RUN edge. `MATCH` is not sampled on the edge that enters RUN.
- All outputs are registered, with no combinational input-to-output paths.
- Throughput: one window result per `WIN_LEN` cycles. A reader asserting `WIN_READY` constantly never sees an overrun.

## Configuration

- `MATCH_ALARM_EN` defined: the `THRESH` comparator and the `ALARM` register are compiled in, behaving as described above.
- `MATCH_ALARM_EN` undefined: the comparator and register are omitted; `ALARM` is tied to 0 and `THRESH` is unused. Everything else is unchanged.

## Test plan

Default parameters, `MATCH_ALARM_EN` defined, unless stated.

- Reset, then `EN`=1; `MATCH` high only at RUN indices 2, 5 and 9; `WIN_READY`=0 -> after 16 RUN cycles `WIN_VALID`=1, `WIN_COUNT`=3, `ALARM`=1, `TOTAL`=3.
- `WIN_READY`=0 across two windows with 1 then 2 matches -> `WIN_COUNT`=2 and `OVERRUN`=1. Then `WIN_READY`=1 for one cycle -> `WIN_VALID`=0 next edge, `OVERRUN` still 1.
- `MATCH`=1 for 300 RUN cycles with `WIN_READY`=1 -> `TOTAL` saturates at 255, and every window reports `WIN_COUNT`=16.
- 4 matches, then `EN`=0 at RUN index 10 -> no `WIN_VALID`, `TOTAL`=4. After re-enabling, the next completion occurs 16 RUN cycles later.
- `CLEAR` with `MATCH`=1 -> `TOTAL`=0. `CLEAR` on the edge of a completion with 5 matches -> `ALARM`=1.
- `reset` pulsed with `WIN_VALID`=1 and `ALARM`=1 -> all outputs 0 next edge. Rebuild without `MATCH_ALARM_EN` and rerun the first scenario -> `ALARM` stays 0.
